// File: rtl/pipeline_hold_ctrl_pkg.sv
// Shared hold/flush codes and controller state encodings.
package pipeline_hold_ctrl_pkg;

  localparam int HOLD_FLAG_W = 3;
  localparam int CNT_W       = 3;

  // Codes decoded by every hold-aware pipeline register; 101..111 are reserved.
  typedef enum logic [HOLD_FLAG_W-1:0] {
    HOLD_NONE  = 3'b000,
    FLUSH_JUMP = 3'b001,
    HOLD_STALL = 3'b010,
    FLUSH_IRQ  = 3'b011,
    HOLD_BUS   = 3'b100
  } hold_code_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_BUS_WAIT = 2'd2
  } ctrl_state_e;

  // Flush counter load value: the first FLUSH_JUMP cycle is issued from IDLE,
  // so the counter only covers the remaining cycles.
  function automatic logic [CNT_W-1:0] flush_cnt_load(input int flush_cycles);
    return CNT_W'(flush_cycles - 1);
  endfunction

endpackage

// File: rtl/pipeline_hold_ctrl_if.sv
// Hold/flush request and redirect signals between the controller and the pipeline.
interface pipeline_hold_ctrl_if #(
  parameter int ADDR_W = 32
);
  import pipeline_hold_ctrl_pkg::*;

  logic                   jump_req_i;
  logic [ADDR_W-1:0]      jump_addr_i;
  logic                   stall_req_i;
  logic                   bus_wait_i;
  logic                   irq_req_i;
  logic [HOLD_FLAG_W-1:0] hold_flag_o;
  logic                   redirect_valid_o;
  logic [ADDR_W-1:0]      redirect_addr_o;
  logic                   irq_ack_o;

  modport master (
    input  jump_req_i, jump_addr_i, stall_req_i, bus_wait_i, irq_req_i,
    output hold_flag_o, redirect_valid_o, redirect_addr_o, irq_ack_o
  );

  modport slave (
    output jump_req_i, jump_addr_i, stall_req_i, bus_wait_i, irq_req_i,
    input  hold_flag_o, redirect_valid_o, redirect_addr_o, irq_ack_o
  );

endinterface

// File: rtl/pipeline_hold_ctrl_jump_pend_buf.sv
// Holds one jump that arrived while the memory stage was stalled.
// The first captured jump wins; further captures are ignored until cleared.
module pipeline_hold_ctrl_jump_pend_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              vld,
  output logic [ADDR_W-1:0] addr
);

  // Capture-once / clear register for the pending jump target.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      addr <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (capture && !vld) begin
      vld  <= 1'b1;
      addr <= addr_in;
    end
  end

endmodule

// File: rtl/pipeline_hold_ctrl.sv
// Central pipeline hold/flush controller. Outputs are decoded from the
// registered state and the current requests, so they take effect the same cycle.
//
//   state       | meaning
//   ST_IDLE     | normal flow; arbitrates bus wait > jump > irq > stall
//   ST_FLUSH    | remaining FLUSH_JUMP cycles of an accepted jump (cnt left)
//   ST_BUS_WAIT | memory stalled; at most one jump parked in the pend buffer
module pipeline_hold_ctrl
  import pipeline_hold_ctrl_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                FLUSH_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = 'h0000_0100
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hold_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD    = flush_cnt_load(FLUSH_CYCLES);
  localparam bit               MULTI_FLUSH = (FLUSH_CYCLES > 1);

  ctrl_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             irq_armed, irq_armed_nxt;

  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_capture, pend_clear;

  logic              apply_idle;
  logic              take_jump;
  logic [ADDR_W-1:0] jump_target;

  hold_code_e        hold;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              irq_ack;

  pipeline_hold_ctrl_jump_pend_buf #(
    .ADDR_W(ADDR_W)
  ) u_jump_pend_buf (
    .clk     (clk),
    .rst     (rst),
    .capture (pend_capture),
    .clear   (pend_clear),
    .addr_in (bus.jump_addr_i),
    .vld     (pend_vld),
    .addr    (pend_addr)
  );

  // Next-state and Mealy output decode.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    irq_armed_nxt  = irq_armed | ~bus.irq_req_i;
    pend_capture   = 1'b0;
    pend_clear     = 1'b0;
    apply_idle     = 1'b0;
    take_jump      = 1'b0;
    jump_target    = bus.jump_addr_i;
    hold           = HOLD_NONE;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    irq_ack        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.bus_wait_i) begin
          hold         = HOLD_BUS;
          pend_capture = bus.jump_req_i;
          state_nxt    = ST_BUS_WAIT;
        end else begin
          apply_idle = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Requests seen here come from the wrong path and are dropped.
        if (bus.bus_wait_i) begin
          hold = HOLD_BUS;
        end else begin
          hold    = FLUSH_JUMP;
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
        end
      end
      ST_BUS_WAIT: begin
        if (bus.bus_wait_i) begin
          hold         = HOLD_BUS;
          pend_capture = bus.jump_req_i;
        end else if (pend_vld) begin
          take_jump   = 1'b1;
          jump_target = pend_addr;
          pend_clear  = 1'b1;
        end else begin
          apply_idle = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (apply_idle) begin
      state_nxt = ST_IDLE;
      if (bus.jump_req_i) begin
        take_jump = 1'b1;
      end else if (bus.irq_req_i && irq_armed) begin
        hold           = FLUSH_IRQ;
        redirect_valid = 1'b1;
        redirect_addr  = IRQ_VECTOR;
        irq_ack        = 1'b1;
        irq_armed_nxt  = 1'b0;
      end else if (bus.stall_req_i) begin
        hold = HOLD_STALL;
      end
    end

    if (take_jump) begin
      hold           = FLUSH_JUMP;
      redirect_valid = 1'b1;
      redirect_addr  = jump_target;
      if (MULTI_FLUSH) begin
        state_nxt = ST_FLUSH;
        cnt_nxt   = CNT_LOAD;
      end else begin
        state_nxt = ST_IDLE;
      end
    end

    // Outputs stay quiet while reset is held, whatever the inputs do.
    if (rst) begin
      hold           = HOLD_NONE;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      irq_ack        = 1'b0;
    end
  end

  // State, flush counter and interrupt re-arm registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      irq_armed <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      irq_armed <= irq_armed_nxt;
    end
  end

  assign bus.hold_flag_o      = hold;
  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_addr_o  = redirect_addr;
  assign bus.irq_ack_o        = irq_ack;

endmodule
